// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes and
// datapath mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC      = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_JAL       = 4'd11,
    S_JR        = 4'd12,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR    = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC     = 2'b10;

  localparam logic [1:0] ALU_B_RT      = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // States that stall on the shared SRAM and are guarded by the wait timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state; expired flags the
// cycle in which the budget is exhausted and the access still has not completed.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  input  logic ready,
  output logic expired
);

  localparam int W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);

  logic [W-1:0] cnt_q;
  logic         at_limit;

  assign at_limit = (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count && !ready && !at_limit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A ready arriving in the limit cycle still counts as success.
  assign expired = count && !ready && at_limit;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore decode of datapath controls, SRAM wait
// supervision, and sticky traps for illegal opcodes and memory timeouts.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_cen,
  output logic       mem_wen,
  output logic       mem_oen,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       err_illegal,
  output logic       err_timeout
);

  // state       | meaning
  // IDLE        | post-reset, single cycle
  // FETCH       | read instruction at PC, PC += 4 on ready
  // DECODE      | register read, branch target into ALUOut
  // MEM_ADDR    | effective address for lw/sw
  // MEM_READ    | lw data access
  // MEM_WB      | MDR -> rt
  // MEM_WRITE   | sw data access
  // EXEC        | R-type ALU operation
  // R_WB        | ALUOut -> rd
  // BRANCH      | beq compare, PC <- target if equal
  // JUMP / JAL  | PC <- jump target (JAL also links r31)
  // JR          | PC <- rs
  // TRAP        | absorbing until reset

  state_t state_q, state_d;
  logic   timer_clear, timer_count, timer_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)          state_d = S_DECODE;
        else if (timer_expired) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = (funct == FUNCT_JR) ? S_JR : S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready)          state_d = S_MEM_WB;
        else if (timer_expired) state_d = S_TRAP;
      end
      S_MEM_WRITE: begin
        if (mem_ready)          state_d = S_FETCH;
        else if (timer_expired) state_d = S_TRAP;
      end
      S_EXEC:      state_d = S_R_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
  end

  // The counter restarts whenever a memory state is newly entered.
  assign timer_clear = is_wait_state(state_d) && (state_d != state_q);
  assign timer_count = is_wait_state(state_q);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .count   (timer_count),
    .ready   (mem_ready),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (state_q == S_DECODE && state_d == S_TRAP) err_illegal <= 1'b1;
      if (timer_expired)                            err_timeout <= 1'b1;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_cen    = 1'b1;
    mem_wen    = 1'b1;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = MEM_TO_REG_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = ALU_B_RT;
    alu_op     = ALU_OP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_cen   = 1'b0;
        alu_src_b = ALU_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = ALU_B_IMM_SH2;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
      end
      S_MEM_READ: begin
        iord    = 1'b1;
        mem_cen = 1'b0;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = MEM_TO_REG_MDR;
      end
      S_MEM_WRITE: begin
        iord    = 1'b1;
        mem_cen = 1'b0;
        mem_wen = 1'b0;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = REG_DST_RD;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
      end
      S_JAL: begin
        pc_src     = PC_SRC_JUMP;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = REG_DST_R31;
        mem_to_reg = MEM_TO_REG_PC;
      end
      S_JR: begin
        pc_src   = PC_SRC_RS;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_oen = 1'b0;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed cycle scripts push expected
// state/controls; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam int MAX_WAIT = 15;

  localparam logic [3:0] ST_IDLE = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2;
  localparam logic [3:0] ST_MADDR = 4'd3, ST_MREAD = 4'd4,  ST_MWB = 4'd5;
  localparam logic [3:0] ST_MWRITE = 4'd6, ST_EXEC = 4'd7,  ST_RWB = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_JAL = 4'd11;
  localparam logic [3:0] ST_JR = 4'd12,   ST_TRAP = 4'd15;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_cen;
    logic       mem_wen;
    logic       mem_oen;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       err_illegal;
    logic       err_timeout;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    ctl_t       ctl;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, ir_write, iord, mem_cen, mem_wen, mem_oen, reg_write;
  logic       alu_src_a, err_illegal, err_timeout;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
  logic [3:0] state;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_ill = 1'b0, exp_to = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .iord(iord), .mem_cen(mem_cen), .mem_wen(mem_wen),
    .mem_oen(mem_oen), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .err_illegal(err_illegal),
    .err_timeout(err_timeout)
  );

  // Hand-written control table for each state.
  function automatic ctl_t exp_ctl(input logic [3:0] s, input logic rdy, input logic z);
    ctl_t c;
    c = '0;
    c.mem_cen = 1'b1;
    c.mem_wen = 1'b1;
    case (s)
      ST_FETCH:  begin c.mem_cen = 1'b0; c.alu_src_b = 2'b01; c.pc_write = rdy; c.ir_write = rdy; end
      ST_DECODE: c.alu_src_b = 2'b11;
      ST_MADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ST_MREAD:  begin c.iord = 1'b1; c.mem_cen = 1'b0; end
      ST_MWB:    begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
      ST_MWRITE: begin c.iord = 1'b1; c.mem_cen = 1'b0; c.mem_wen = 1'b0; end
      ST_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      ST_RWB:    begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
      ST_BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_write = z; end
      ST_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      ST_JAL:    begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.reg_write = 1'b1;
                       c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
      ST_JR:     begin c.pc_src = 2'b11; c.pc_write = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  // Drive inputs for the current cycle, record expectation, advance one clock.
  task automatic cyc(input logic rdy, input logic z, input logic [3:0] s, input string nm);
    exp_t e;
    mem_ready = rdy;
    zero      = z;
    e.st      = s;
    e.ctl     = exp_ctl(s, rdy, z);
    e.ctl.err_illegal = exp_ill;
    e.ctl.err_timeout = exp_to;
    e.name    = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    exp_ill = 1'b0;
    exp_to  = 1'b0;
    cyc(1'b0, 1'b0, ST_IDLE, "reset");
    cyc(1'b1, 1'b0, ST_IDLE, "reset");
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, ST_IDLE, "reset_release");
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      ctl_t act;
      e = sb.pop_front();
      act = '{pc_write, pc_src, ir_write, iord, mem_cen, mem_wen, mem_oen, reg_write,
              reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, err_illegal, err_timeout};
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d want %0d", e.name, state, e.st);
      end
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL %s controls: got %h want %h", e.name, act, e.ctl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // lw, zero-wait: 1,2,3,4,5 then 1
    opcode = 6'b100011;
    cyc(1, 0, ST_FETCH, "lw_fetch");   cyc(1, 0, ST_DECODE, "lw_decode");
    cyc(1, 0, ST_MADDR, "lw_maddr");   cyc(1, 0, ST_MREAD, "lw_mread");
    cyc(1, 0, ST_MWB, "lw_wb");

    // sw, three not-ready cycles in MEM_WRITE
    opcode = 6'b101011;
    cyc(1, 0, ST_FETCH, "sw_fetch");   cyc(1, 0, ST_DECODE, "sw_decode");
    cyc(1, 0, ST_MADDR, "sw_maddr");
    repeat (3) cyc(0, 0, ST_MWRITE, "sw_wait");
    cyc(1, 0, ST_MWRITE, "sw_done");

    // beq not taken, then taken
    opcode = 6'b000100;
    cyc(1, 0, ST_FETCH, "beq0_fetch"); cyc(1, 0, ST_DECODE, "beq0_decode");
    cyc(1, 0, ST_BRANCH, "beq_not_taken");
    cyc(1, 1, ST_FETCH, "beq1_fetch"); cyc(1, 1, ST_DECODE, "beq1_decode");
    cyc(1, 1, ST_BRANCH, "beq_taken");

    // R-type add, then jr
    opcode = 6'b000000; funct = 6'b100000;
    cyc(1, 0, ST_FETCH, "r_fetch");    cyc(1, 0, ST_DECODE, "r_decode");
    cyc(1, 0, ST_EXEC, "r_exec");      cyc(1, 0, ST_RWB, "r_wb");
    funct = 6'b001000;
    cyc(1, 0, ST_FETCH, "jr_fetch");   cyc(1, 0, ST_DECODE, "jr_decode");
    cyc(1, 0, ST_JR, "jr");

    // j, jal
    opcode = 6'b000010;
    cyc(1, 0, ST_FETCH, "j_fetch");    cyc(1, 0, ST_DECODE, "j_decode");
    cyc(1, 0, ST_JUMP, "j");
    opcode = 6'b000011;
    cyc(1, 0, ST_FETCH, "jal_fetch");  cyc(1, 0, ST_DECODE, "jal_decode");
    cyc(1, 0, ST_JAL, "jal");

    // lw: counter must restart on entry to MEM_READ, then succeed at the limit
    opcode = 6'b100011;
    repeat (10) cyc(0, 0, ST_FETCH, "lw2_fetch_wait");
    cyc(1, 0, ST_FETCH, "lw2_fetch");  cyc(1, 0, ST_DECODE, "lw2_decode");
    cyc(1, 0, ST_MADDR, "lw2_maddr");
    repeat (MAX_WAIT) cyc(0, 0, ST_MREAD, "lw2_mread_wait");
    cyc(1, 0, ST_MREAD, "lw2_mread_limit_ok");
    cyc(1, 0, ST_MWB, "lw2_wb");

    // fetch ready on the final permitted cycle: no trap
    opcode = 6'b000010;
    repeat (MAX_WAIT) cyc(0, 0, ST_FETCH, "fetch_wait");
    cyc(1, 0, ST_FETCH, "fetch_limit_ok");
    cyc(1, 0, ST_DECODE, "limit_decode");
    cyc(1, 0, ST_JUMP, "limit_jump");

    // fetch timeout after MAX_WAIT+1 not-ready cycles
    repeat (MAX_WAIT + 1) cyc(0, 0, ST_FETCH, "to_fetch_wait");
    exp_to = 1'b1;
    repeat (3) cyc(0, 0, ST_TRAP, "to_trap");
    cyc(1, 1, ST_TRAP, "to_trap_ready");
    do_reset();

    // illegal opcode: trap held 20 cycles, reset returns to IDLE
    opcode = 6'b111111;
    cyc(1, 0, ST_FETCH, "ill_fetch");  cyc(1, 0, ST_DECODE, "ill_decode");
    exp_ill = 1'b1;
    repeat (20) cyc(1, 1, ST_TRAP, "ill_trap");
    do_reset();

    // reset mid-sw and at the start of lw writeback aborts with no strobes
    opcode = 6'b101011;
    cyc(1, 0, ST_FETCH, "abort_sw_fetch"); cyc(1, 0, ST_DECODE, "abort_sw_decode");
    cyc(1, 0, ST_MADDR, "abort_sw_maddr"); cyc(0, 0, ST_MWRITE, "abort_sw_write");
    do_reset();
    opcode = 6'b100011;
    cyc(1, 0, ST_FETCH, "abort_lw_fetch"); cyc(1, 0, ST_DECODE, "abort_lw_decode");
    cyc(1, 0, ST_MADDR, "abort_lw_maddr"); cyc(1, 0, ST_MREAD, "abort_lw_mread");
    do_reset();

    opcode = 6'b000011;
    cyc(1, 0, ST_FETCH, "post_fetch"); cyc(1, 0, ST_DECODE, "post_decode");
    cyc(1, 0, ST_JAL, "post_jal");

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
